// File: rtl/aftab_divider_result_stage_if.sv
// Command, divider and result handshake bundle of the AFTAB divider result stage.
// The stage itself is the slave; the command source / divider / writeback side is the master.
interface aftab_divider_result_stage_if #(
    parameter int len = 32
);
    logic           cmdValid;
    logic           cmdReady;
    logic [1:0]     funct;
    logic [len-1:0] dividendIn;
    logic [len-1:0] divisorIn;
    logic           divStart;
    logic           divDone;
    logic [len:0]   divQ;
    logic [len+1:0] divR;
    logic           resValid;
    logic           resReady;
    logic [len-1:0] result;

    modport slave (
        input  cmdValid, funct, dividendIn, divisorIn, divDone, divQ, divR, resReady,
        output cmdReady, divStart, resValid, result
    );

    modport master (
        output cmdValid, funct, dividendIn, divisorIn, divDone, divQ, divR, resReady,
        input  cmdReady, divStart, resValid, result
    );
endinterface

// File: rtl/aftab_divider_result_stage.sv
// RV32M divide/remainder result stage: sign-corrects the unsigned divider's magnitudes,
// resolves divide-by-zero and signed overflow locally, and holds the result under valid/ready.
module aftab_divider_result_stage #(
    parameter int len = 32
) (
    input logic                           clk,
    input logic                           rst,
    aftab_divider_result_stage_if.slave   bus
);
    typedef enum logic [1:0] {IDLE, WAIT, CORRECT, HOLD} state_t;

    localparam logic [len-1:0] MIN_NEG = {1'b1, {(len-1){1'b0}}};

    state_t         state_q;
    logic           cmd_ready_q;
    logic           res_valid_q;
    logic [len-1:0] result_q;
    logic [len-1:0] q_q;
    logic [len-1:0] r_q;
    logic           is_rem_q;
    logic           sign_a_q;
    logic           sign_b_q;

    logic           accept;
    logic           is_signed;
    logic           zero_div;
    logic           ovf;
    logic           special;
    logic [len-1:0] special_result_d;
    logic [len-1:0] corr_result_d;

    // NOTE: every signal gets a value on every path through always_comb so no latch is inferred.
    always_comb begin
        is_signed = ~bus.funct[0];
        accept    = (state_q == IDLE) && bus.cmdValid;
        zero_div  = (bus.divisorIn == '0);
        ovf       = is_signed && (bus.dividendIn == MIN_NEG) && (bus.divisorIn == '1);
        special   = zero_div | ovf;

        // Divide-by-zero wins; its remainder is the raw dividend with no sign fix.
        if (zero_div) begin
            special_result_d = bus.funct[1] ? bus.dividendIn : '1;
        end else begin
            special_result_d = bus.funct[1] ? '0 : MIN_NEG;
        end

        // Quotient is negative when operand signs differ; remainder follows the dividend.
        if (is_rem_q) begin
            corr_result_d = sign_a_q ? -r_q : r_q;
        end else begin
            corr_result_d = (sign_a_q ^ sign_b_q) ? -q_q : q_q;
        end
    end

    assign bus.divStart = accept & ~special;
    assign bus.cmdReady = cmd_ready_q;
    assign bus.resValid = res_valid_q;
    assign bus.result   = result_q;

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cmd_ready_q <= 1'b1;
            res_valid_q <= 1'b0;
            result_q    <= '0;
            q_q         <= '0;
            r_q         <= '0;
            is_rem_q    <= 1'b0;
            sign_a_q    <= 1'b0;
            sign_b_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        is_rem_q    <= bus.funct[1];
                        sign_a_q    <= bus.dividendIn[len-1] & is_signed;
                        sign_b_q    <= bus.divisorIn[len-1] & is_signed;
                        cmd_ready_q <= 1'b0;
                        if (special) begin
                            result_q    <= special_result_d;
                            res_valid_q <= 1'b1;
                            state_q     <= HOLD;
                        end else begin
                            state_q     <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    // Only the low len bits of the divider outputs carry the magnitude.
                    if (bus.divDone) begin
                        q_q     <= bus.divQ[len-1:0];
                        r_q     <= bus.divR[len-1:0];
                        state_q <= CORRECT;
                    end
                end
                CORRECT: begin
                    result_q    <= corr_result_d;
                    res_valid_q <= 1'b1;
                    state_q     <= HOLD;
                end
                HOLD: begin
                    if (bus.resReady) begin
                        res_valid_q <= 1'b0;
                        cmd_ready_q <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_aftab_divider_result_stage.sv
// Self-checking bench for aftab_divider_result_stage: directed RV32M corner cases plus random
// operations, each compared against RISC-V division semantics computed with plain arithmetic.
module tb_aftab_divider_result_stage;
    localparam int LEN = 32;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    aftab_divider_result_stage_if #(.len(LEN)) bus ();

    aftab_divider_result_stage #(.len(LEN)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [LEN-1:0] observed, input logic [LEN-1:0] expected);
        n_checks++;
        assert (observed === expected)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    // RISC-V M-extension result for funct/operands, including both special cases.
    function automatic logic [LEN-1:0] ref_result(input logic [1:0] f, input logic [LEN-1:0] a,
                                                  input logic [LEN-1:0] b);
        logic signed [LEN-1:0] sa;
        logic signed [LEN-1:0] sb;
        sa = a;
        sb = b;
        if (b == 0) return f[1] ? a : 32'hFFFF_FFFF;
        if (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return f[1] ? 32'h0 : 32'h8000_0000;
        case (f)
            2'b00:   return sa / sb;
            2'b01:   return a / b;
            2'b10:   return sa % sb;
            default: return a % b;
        endcase
    endfunction

    function automatic logic [LEN-1:0] mag(input logic [LEN-1:0] v, input logic is_signed);
        return (is_signed && v[LEN-1]) ? -v : v;
    endfunction

    task automatic idle_inputs();
        bus.cmdValid   = 1'b0;
        bus.funct      = 2'b00;
        bus.dividendIn = '0;
        bus.divisorIn  = '0;
        bus.divDone    = 1'b0;
        bus.divQ       = '0;
        bus.divR       = '0;
        bus.resReady   = 1'b0;
    endtask

    // One full command: accept, optional divider wait, hold with backpressure, handshake.
    task automatic run_op(input logic [1:0] f, input logic [LEN-1:0] a, input logic [LEN-1:0] b,
                          input int wait_cyc, input int bp_cyc);
        logic           special;
        logic [LEN-1:0] exp;
        logic [LEN-1:0] ua;
        logic [LEN-1:0] ub;
        special = (b == 0) || (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
        exp     = ref_result(f, a, b);
        ua      = mag(a, !f[0]);
        ub      = mag(b, !f[0]);

        @(negedge clk);
        bus.cmdValid   = 1'b1;
        bus.funct      = f;
        bus.dividendIn = a;
        bus.divisorIn  = b;
        bus.divDone    = 1'b1;
        bus.divQ       = {1'b0, $urandom()};
        bus.divR       = {2'b00, $urandom()};
        #1;
        check("accept_cmdReady", 32'(bus.cmdReady), 32'd1);
        check("accept_divStart", 32'(bus.divStart), 32'(!special));

        @(negedge clk);
        bus.cmdValid = 1'b0;
        bus.divDone  = 1'b0;
        #1;
        check("post_accept_cmdReady", 32'(bus.cmdReady), 32'd0);
        check("post_accept_divStart", 32'(bus.divStart), 32'd0);

        if (!special) begin
            for (int i = 0; i < wait_cyc; i++) begin
                check("wait_resValid", 32'(bus.resValid), 32'd0);
                @(negedge clk);
            end
            bus.divDone = 1'b1;
            bus.divQ    = {1'($urandom()), ua / ub};
            bus.divR    = {2'($urandom()), ua % ub};
            @(negedge clk);
            bus.divDone = 1'b0;
            bus.divQ    = '0;
            bus.divR    = '0;
            #1;
            check("correct_resValid", 32'(bus.resValid), 32'd0);
            @(negedge clk);
        end

        bus.resReady = 1'b0;
        for (int i = 0; i < bp_cyc; i++) begin
            #1;
            check("hold_resValid", 32'(bus.resValid), 32'd1);
            check("hold_result", bus.result, exp);
            check("hold_cmdReady", 32'(bus.cmdReady), 32'd0);
            bus.divDone = 1'($urandom());
            bus.divQ    = {1'b0, $urandom()};
            bus.divR    = {2'b00, $urandom()};
            @(negedge clk);
        end
        bus.divDone = 1'b0;
        #1;
        check("handshake_resValid", 32'(bus.resValid), 32'd1);
        check("handshake_result", bus.result, exp);
        bus.resReady = 1'b1;
        @(negedge clk);
        bus.resReady = 1'b0;
        #1;
        check("after_hs_resValid", 32'(bus.resValid), 32'd0);
        check("after_hs_cmdReady", 32'(bus.cmdReady), 32'd1);
        check("after_hs_result_kept", bus.result, exp);
    endtask

    initial begin
        logic [1:0]     f;
        logic [LEN-1:0] a;
        logic [LEN-1:0] b;
        n_checks = 0;
        n_fail   = 0;
        idle_inputs();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        check("reset_cmdReady", 32'(bus.cmdReady), 32'd1);
        check("reset_resValid", 32'(bus.resValid), 32'd0);
        check("reset_result", bus.result, 32'd0);
        check("reset_divStart", 32'(bus.divStart), 32'd0);

        // Directed corner cases
        run_op(2'b00, 32'hFFFF_FFF9, 32'd2, 1, 0);            // DIV -7/2   -> -3
        run_op(2'b10, 32'hFFFF_FFF9, 32'd2, 0, 1);            // REM -7/2   -> -1
        run_op(2'b01, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 2, 0);    // DIVU       -> 0
        run_op(2'b11, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 0, 0);    // REMU       -> 0xFFFFFFFE
        run_op(2'b00, 32'd5, 32'd0, 0, 0);                    // DIV by zero
        run_op(2'b11, 32'd7, 32'd0, 0, 2);                    // REMU by zero -> 7
        run_op(2'b10, 32'hFFFF_FFF9, 32'd0, 0, 0);            // REM by zero keeps raw dividend
        run_op(2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0);    // signed overflow
        run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0);    // overflow remainder -> 0
        run_op(2'b01, 32'h8000_0000, 32'hFFFF_FFFF, 1, 0);    // unsigned: not an overflow
        run_op(2'b00, 32'd100, 32'hFFFF_FFF9, 3, 5);          // backpressure with divDone noise

        // Reset during WAIT discards the operation; a late divDone is ignored.
        @(negedge clk);
        bus.cmdValid   = 1'b1;
        bus.funct      = 2'b00;
        bus.dividendIn = 32'd50;
        bus.divisorIn  = 32'd3;
        @(negedge clk);
        bus.cmdValid = 1'b0;
        rst          = 1'b1;
        @(negedge clk);
        rst          = 1'b0;
        bus.divDone  = 1'b1;
        bus.divQ     = 33'd16;
        bus.divR     = 34'd2;
        @(negedge clk);
        bus.divDone = 1'b0;
        #1;
        check("rst_wait_resValid", 32'(bus.resValid), 32'd0);
        check("rst_wait_cmdReady", 32'(bus.cmdReady), 32'd1);
        check("rst_wait_result", bus.result, 32'd0);
        @(negedge clk);
        #1;
        check("rst_wait_resValid_later", 32'(bus.resValid), 32'd0);

        // Random operations with occasional special operands
        for (int n = 0; n < 60; n++) begin
            f = 2'($urandom());
            a = $urandom();
            b = $urandom();
            case ($urandom_range(0, 7))
                0: b = 32'd0;
                1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                2: b = 32'($urandom_range(1, 9));
                3: b = -32'($urandom_range(1, 9));
                4: a = 32'($urandom_range(0, 20));
                default: ;
            endcase
            run_op(f, a, b, $urandom_range(0, 4), $urandom_range(0, 3));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
